pc_debug_controller: RTL

//  Execution controller driving the PC/pipeline control inputs: enable, flush, clear.

---
 rtl/pc_debug_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pc_debug_controller.sv
// Purpose : debug execution controller; turns RUN/STEP/STOP/FLUSH/CLEAR commands
//           into enable/flush/clear control for the PC/IF stage; halts on retired halt.
// Latency : control outputs are Moore (decoded from the state register); o_done and
//           o_cmd_error are registered and appear in the cycle after the causing edge.
// Backpressure: o_cmd_ready is low in STEP/FLUSH/CLEAR; commands offered then are
//           dropped silently (no error, no queueing).
//
// Ports:
//   i_clk, i_reset          clock (rising edge), async active-high reset
//   i_cmd_valid, i_cmd      command strobe and code (0 NOP,1 RUN,2 STEP,3 STOP,4 FLUSH,5 CLEAR)
//   i_halt_seen             halt instruction retired (level, sampled each edge)
//   o_cmd_ready             command accepted this cycle when valid
//   o_enable/o_flush/o_clear pipeline control
//   o_done, o_cmd_error     single-cycle completion / rejection pulses
//   o_state                 current state encoding
//   o_cycle_count           saturating count of enabled cycles since CLEAR/reset
module pc_debug_controller #(
   parameter int CYCLE_COUNT_BITS = 32
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_cmd_valid,
   input  logic [2:0]                  i_cmd,
   input  logic                        i_halt_seen,
   output logic                        o_cmd_ready,
   output logic                        o_enable,
   output logic                        o_flush,
   output logic                        o_clear,
   output logic                        o_done,
   output logic                        o_cmd_error,
   output logic [2:0]                  o_state,
   output logic [CYCLE_COUNT_BITS-1:0] o_cycle_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_STEP   = 3'd2;
   localparam logic [2:0] S_FLUSH  = 3'd3;
   localparam logic [2:0] S_CLEAR  = 3'd4;
   localparam logic [2:0] S_HALTED = 3'd5;

   localparam logic [2:0] C_NOP   = 3'd0;
   localparam logic [2:0] C_RUN   = 3'd1;
   localparam logic [2:0] C_STEP  = 3'd2;
   localparam logic [2:0] C_STOP  = 3'd3;
   localparam logic [2:0] C_FLUSH = 3'd4;
   localparam logic [2:0] C_CLEAR = 3'd5;

   logic [2:0]                  state_q, state_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
   logic [CYCLE_COUNT_BITS-1:0] count_q, count_d;
   logic                        accept;

   // Moore decode straight from the state register so reset drops them at once.
   assign o_enable    = (state_q == S_RUN) || (state_q == S_STEP);
   assign o_flush     = (state_q == S_FLUSH);
   assign o_clear     = (state_q == S_CLEAR);
   assign o_cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_HALTED);
   assign o_done      = done_q;
   assign o_cmd_error = err_q;
   assign o_state     = state_q;
   assign o_cycle_count = count_q;

   assign accept = i_cmd_valid && o_cmd_ready;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (accept) begin
               case (i_cmd)
                  C_NOP: ;
                  C_RUN: begin
                     if (state_q == S_IDLE) state_d = S_RUN;
                     else                   err_d   = 1'b1;
                  end
                  C_STEP: begin
                     if (state_q == S_IDLE) state_d = S_STEP;
                     else                   err_d   = 1'b1;
                  end
                  C_STOP: begin
                     // STOP while idle just acknowledges; while halted it is refused.
                     if (state_q == S_IDLE) done_d = 1'b1;
                     else                   err_d  = 1'b1;
                  end
                  C_FLUSH: state_d = S_FLUSH;
                  C_CLEAR: state_d = S_CLEAR;
                  default: err_d   = 1'b1;
               endcase
            end
         end
         S_RUN: begin
            // Halt outranks any command on the same edge, so only one o_done fires.
            if (i_halt_seen) begin
               state_d = S_HALTED;
               done_d  = 1'b1;
            end else if (accept) begin
               case (i_cmd)
                  C_NOP: ;
                  C_STOP: begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_STEP: begin
            state_d = i_halt_seen ? S_HALTED : S_IDLE;
            done_d  = 1'b1;
         end
         S_FLUSH, S_CLEAR: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Zeroed on the edge leaving CLEAR; otherwise counts enabled edges, saturating.
   always_comb begin
      count_d = count_q;
      if (state_q == S_CLEAR) begin
         count_d = '0;
      end else if (o_enable && (count_q != {CYCLE_COUNT_BITS{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

endmodule
